// File: rtl/fir_pkg.sv
// Shared FIR control types: coefficient width and the loader state encoding.
// Pure declarations; no timing or flow control of its own.
package fir_pkg;

  localparam int COEFF_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2,
    LOAD = 2'd3
  } loader_state_t;

endpackage

// File: rtl/fir_coeff_loader_if.sv
// Coefficient write port plus committed-set outputs between register side and FIR.
// wr_valid/wr_ready handshake on the write side; commit/abort are single-cycle strobes.
interface fir_coeff_loader_if #(
  parameter int N = 4
) ();
  import fir_pkg::*;

  localparam int CW = $clog2(N + 1);

  logic               wr_valid;
  logic [COEFF_W-1:0] wr_data;
  logic               wr_ready;
  logic               commit;
  logic               abort;
  logic [N*COEFF_W-1:0] coeff_out;
  logic               load;
  logic [CW-1:0]      count;
  logic               commit_err;

  modport master (
    output wr_valid, wr_data, commit, abort,
    input  wr_ready, coeff_out, load, count, commit_err
  );

  modport slave (
    input  wr_valid, wr_data, commit, abort,
    output wr_ready, coeff_out, load, count, commit_err
  );

endinterface

// File: rtl/fir_coeff_loader.sv
// Collects N coefficient words into a shadow set and hands it to the FIR on commit.
// Load pulse one cycle after commit; wr_ready drops while the set is full or loading.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  fir_coeff_loader_if.slave bus
);

  localparam int CW = $clog2(N + 1);

  loader_state_t        state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [COEFF_W-1:0]   shadow_q [N];
  logic [COEFF_W-1:0]   shadow_d [N];
  logic [N*COEFF_W-1:0] coeff_q, coeff_d;
  logic                 load_q, load_d;
  logic                 err_q, err_d;
  logic                 wr_ready;
  logic                 accept;

  // Ready depends on state only, so a writer can never see it combinationally loop.
  assign wr_ready = (state_q == IDLE) || (state_q == FILL);
  assign accept   = bus.wr_valid && wr_ready && !bus.abort;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    coeff_d  = coeff_q;
    load_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      IDLE, FILL: begin
        if (bus.commit) begin
          err_d = 1'b1;
        end
        if (bus.abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (accept) begin
          for (int i = 0; i < N; i++) begin
            if (count_q == CW'(i)) begin
              shadow_d[i] = bus.wr_data;
            end
          end
          count_d = count_q + CW'(1);
          state_d = (count_q == CW'(N - 1)) ? FULL : FILL;
        end
      end

      FULL: begin
        // Abort takes priority so a cancelled set never reaches the filter.
        if (bus.abort) begin
          state_d = IDLE;
          count_d = '0;
        end else if (bus.commit) begin
          state_d = LOAD;
          load_d  = 1'b1;
          count_d = '0;
          err_d   = 1'b0;
          for (int i = 0; i < N; i++) begin
            coeff_d[i*COEFF_W +: COEFF_W] = shadow_q[i];
          end
        end
      end

      LOAD: begin
        state_d = IDLE;
        if (bus.commit) begin
          err_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      shadow_q <= '{default: '0};
      coeff_q  <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      coeff_q  <= coeff_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  assign bus.wr_ready   = wr_ready;
  assign bus.count      = count_q;
  assign bus.coeff_out  = coeff_q;
  assign bus.load       = load_q;
  assign bus.commit_err = err_q;

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Writer-side front end for the N-tap FIR coefficient port. Accepts tap coefficients one 16-bit word at a time over a valid/ready handshake, collects them in a shadow register, and on an explicit commit presents the full N×16-bit coefficient bus to the FIR together with a single-cycle load pulse. The block sits between the processor-side register interface and the filter, so the filter never sees a partially written coefficient set.

## Interface
- N, default 4: number of filter taps; legal range N ≥ 3.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_valid  in  1  coefficient word offered.
- wr_data  in  16  coefficient word; the k-th accepted word is tap k+1.
- wr_ready  out  1  loader can accept a word this cycle.
- commit  in  1  request transfer of the shadow set to the filter.
- abort  in  1  discard the partially or fully collected shadow set.
- coeff_out  out  N*16  committed coefficients; tap 1 in bits [15:0], tap N in bits [N*16-1:(N-1)*16].
- load  out  1  one-cycle pulse; coeff_out holds the new set while high.
- count  out  $clog2(N+1)  number of words currently in the shadow set.
- commit_err  out  1  sticky; set by a commit issued outside FULL.

## Operation
- States: IDLE (count = 0), FILL (0 < count < N), FULL (count = N), LOAD (one cycle).
- Write acceptance: wr_valid && wr_ready. The word is stored to shadow slot count, and count increments.
  - IDLE → FILL on the first accepted word.
  - FILL → FULL when the N-th word is accepted.
- wr_ready is 1 in IDLE and FILL, and 0 in FULL and LOAD. wr_valid while wr_ready = 0 is not accepted, is not an error, and does not change state.
- In FULL, commit moves to LOAD. On that edge coeff_out ← shadow, load ← 1, count ← 0, and the shadow set is retained but treated as empty.
- LOAD → IDLE unconditionally after one cycle. load returns to 0.
- commit in IDLE, FILL or LOAD sets commit_err. The commit is otherwise ignored. commit_err clears only on rst or on the next successful commit, in the LOAD cycle.
- abort in IDLE, FILL or FULL: go to IDLE and set count ← 0. coeff_out is unchanged and load is not asserted.
- abort in LOAD is ignored.
- Simultaneous events:
  - abort + wr_valid: abort wins and the word is dropped.
  - abort + commit in FULL: abort wins and no load occurs. commit_err is not set.
  - commit in the same cycle as the N-th write, in FILL: the commit is premature, commit_err is set, and the state goes to FULL.
- coeff_out changes only on the LOAD-entry edge or on reset. Between loads it is stable.
- No arithmetic on data. count saturates at N by construction and never wraps.

## Timing
- Reset values: state IDLE, count 0, shadow all 0, coeff_out 0, load 0, wr_ready 1 after reset deasserts, commit_err 0.
- Reset asserted mid-fill or in LOAD takes effect immediately (asynchronous). Any in-flight load pulse is cut short. The filter sees coeff_out = 0.
- Write to count update: 1 cycle. wr_ready is combinational from state only, with no dependency on wr_valid.
- Commit sampled at edge k in FULL: load = 1 and the new coeff_out are visible in cycle k+1. wr_ready = 1 again in cycle k+2.
- Minimum reload interval: N + 2 cycles. This is N writes, one commit cycle and one LOAD cycle, with back-to-back writes allowed starting in the cycle after LOAD.
- All outputs are registered except wr_ready, which is decoded from the state register.

## Structure
- Shared package fir_pkg holds:
  - COEFF_W = 16.
  - The typedef enum loader_state_t {IDLE, FILL, FULL, LOAD}, reused by any later FIR control blocks.
- A single module. No sub-module is natural; the shadow array and the output register are plain registers inside fir_coeff_loader.
- Shadow storage is an array of N COEFF_W words. coeff_out is packed from it on commit.

## Test plan
- Reset, then write 0x0001, 0x0002, 0x0003, 0x0004 back-to-back, then commit → count reads 1, 2, 3, 4; load pulses for exactly one cycle; coeff_out = 0x0004_0003_0002_0001.
- Write 0x1111 and 0x2222, then abort, then write 0xA, 0xB, 0xC, 0xD and commit → coeff_out = 0x000D_000C_000B_000A. There is no load pulse before the final commit.
- Commit with count = 2 → commit_err = 1, no load, count stays 2. A later full fill plus commit clears commit_err in the LOAD cycle.
- In FULL, hold wr_valid = 1 with 0xFFFF for 3 cycles → wr_ready = 0 throughout, count stays 4, and 0xFFFF never appears in coeff_out.
- Assert rst in the LOAD cycle after loading 0x0005_0006_0007_0008 → load drops and coeff_out = 0 immediately, and the block is in IDLE with wr_ready = 1 after release.
- Assert abort and commit together in FULL → no load, commit_err = 0, count = 0.
